// File: rtl/incdec_unit.sv
// Handshaked add/subtract-by-step unit with optional unsigned/signed saturation,
// status flags and a sticky overflow bit; one registered output stage.
module incdec_unit #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_step,
  input  logic             in_dec,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_satd,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             accept;
  logic [WIDTH:0]   uraw;
  logic [WIDTH+1:0] sraw;
  logic             carry, ovf, ev, satd;
  logic [WIDTH-1:0] res;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             satd_q, satd_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    in_ready = !valid_q || out_ready;
    accept   = in_valid && in_ready;

    // Unsigned view yields carry/borrow in bit WIDTH; the two-bit-wider signed
    // view holds the exact result of a (signed) +/- step (zero-extended).
    if (in_dec) begin
      uraw = {1'b0, in_a} - {1'b0, in_step};
      sraw = {{2{in_a[WIDTH-1]}}, in_a} - {2'b00, in_step};
    end else begin
      uraw = {1'b0, in_a} + {1'b0, in_step};
      sraw = {{2{in_a[WIDTH-1]}}, in_a} + {2'b00, in_step};
    end

    carry = uraw[WIDTH];
    ovf   = (sraw[WIDTH+1] != sraw[WIDTH]) || (sraw[WIDTH] != sraw[WIDTH-1]);
    ev    = (SIGNED != 0) ? ovf : carry;
    satd  = in_sat && ev;

    res = uraw[WIDTH-1:0];
    if (satd) begin
      if (SIGNED != 0) res = in_dec ? SMIN : SMAX;
      else             res = in_dec ? '0 : '1;
    end

    valid_d  = valid_q;
    res_d    = res_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    satd_d   = satd_q;
    sticky_d = sticky_q;

    if (accept) begin
      valid_d = 1'b1;
      res_d   = res;
      carry_d = carry;
      ovf_d   = ovf;
      zero_d  = (res == '0);
      neg_d   = res[WIDTH-1];
      satd_d  = satd;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    // A new overflow event takes priority over a same-cycle clear.
    if (accept && ev)    sticky_d = 1'b1;
    else if (clr_sticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      satd_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      satd_q   <= satd_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_res    = res_q;
  assign out_carry  = carry_q;
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;
  assign out_satd   = satd_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_incdec_unit.sv
// Scoreboard bench for incdec_unit: unsigned and signed instances share one
// stimulus stream; each keeps its own expected-result queue and sticky model.
module tb_incdec_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_dec, in_sat, out_ready, clr_sticky;
  logic [W-1:0] in_a, in_step;
  logic [1:0]   in_ready, out_valid, out_carry, out_ovf, out_zero, out_neg, out_satd, sticky_ovf;
  logic [W-1:0] out_res [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Returns {event, res, carry, ovf, zero, neg, satd}.
  function automatic logic [W+5:0] model(input logic [W-1:0] a, input logic [W-1:0] s,
                                         input logic dec, input logic sat, input logic sgn);
    longint span = longint'(1) << W;
    longint ua = longint'(a);
    longint us = longint'(s);
    longint sa, ur, full;
    logic carry, ovf, ev, satd;
    logic [W-1:0] res;
    sa    = a[W-1] ? ua - span : ua;
    ur    = dec ? ua - us : ua + us;
    carry = dec ? (ua < us) : (ur >= span);
    full  = dec ? sa - us : sa + us;
    ovf   = (full > span / 2 - 1) || (full < -(span / 2));
    ev    = sgn ? ovf : carry;
    satd  = sat && ev;
    res   = ur[W-1:0];
    if (satd) begin
      if (sgn) res = dec ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else     res = dec ? '0 : '1;
    end
    return {ev, res, carry, ovf, (res == '0), res[W-1], satd};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    incdec_unit #(.WIDTH(W), .SIGNED(g)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready[g]),
      .in_a(in_a), .in_step(in_step), .in_dec(in_dec), .in_sat(in_sat),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_res(out_res[g]), .out_carry(out_carry[g]), .out_ovf(out_ovf[g]),
      .out_zero(out_zero[g]), .out_neg(out_neg[g]), .out_satd(out_satd[g]),
      .sticky_ovf(sticky_ovf[g]), .clr_sticky(clr_sticky)
    );

    logic [W+4:0] obs;
    assign obs = {out_res[g], out_carry[g], out_ovf[g], out_zero[g], out_neg[g], out_satd[g]};

    logic [W+4:0] sb [$];
    logic [W+4:0] held;
    logic         held_v = 1'b0;
    logic         sticky_exp = 1'b0;

    always @(negedge clk) begin
      logic [W+5:0] m;
      logic         acc;
      if (rst) begin
        sb.delete();
        sticky_exp = 1'b0;
        held_v     = 1'b0;
      end else begin
        check(g ? "s_out_valid" : "u_out_valid", out_valid[g], sb.size() != 0);
        check(g ? "s_in_ready" : "u_in_ready", in_ready[g], (sb.size() == 0) || out_ready);
        check(g ? "s_sticky" : "u_sticky", sticky_ovf[g], sticky_exp);
        if (held_v) check(g ? "s_hold" : "u_hold", obs, held);
        held_v = out_valid[g] && !out_ready;
        held   = obs;
        acc    = in_valid && ((sb.size() == 0) || out_ready);
        if (out_valid[g] && out_ready && sb.size() != 0)
          check(g ? "s_result" : "u_result", obs, sb.pop_front());
        if (acc) begin
          m = model(in_a, in_step, in_dec, in_sat, g[0]);
          sb.push_back(m[W+4:0]);
        end
        if (acc && m[W+5]) sticky_exp = 1'b1;
        else if (clr_sticky) sticky_exp = 1'b0;
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] s,
                       input logic dec, input logic sat, input logic clr);
    in_valid = 1'b1; in_a = a; in_step = s; in_dec = dec; in_sat = sat; clr_sticky = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; clr_sticky = 1'b0;
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] s, input logic dec,
                          input logic sat, input logic [W-1:0] eu, input logic [W-1:0] es);
    drive(a, s, dec, sat, 1'b0);
    check("dir_res_u", out_res[0], eu);
    check("dir_res_s", out_res[1], es);
  endtask

  initial begin
    int k;
    logic acc;
    logic [W-1:0] sa [4];
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; clr_sticky = 1'b0;
    in_a = 16'hFFFF; in_step = 16'h0001; in_dec = 1'b0; in_sat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 2'b00);
    check("rst_res_u", out_res[0], 16'h0000);
    check("rst_res_s", out_res[1], 16'h0000);
    check("rst_flags", {out_carry, out_ovf, out_zero, out_neg, out_satd}, 10'h000);
    check("rst_sticky", sticky_ovf, 2'b00);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 2'b11);

    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("wrap_carry_u", out_carry[0], 1'b1);
    check("wrap_zero_u", out_zero[0], 1'b1);
    check("wrap_sticky_u", sticky_ovf[0], 1'b1);
    directed(16'h000B, 16'h0001, 1'b0, 1'b0, 16'h000C, 16'h000C);
    check("inc_carry_u", out_carry[0], 1'b0);
    directed(16'h0003, 16'h0005, 1'b1, 1'b1, 16'h0000, 16'hFFFE);
    check("dec_sat_u", {out_carry[0], out_satd[0]}, 2'b11);
    directed(16'hFFF0, 16'h0020, 1'b0, 1'b1, 16'hFFFF, 16'h0010);
    check("inc_sat_u", out_satd[0], 1'b1);
    directed(16'h7FFE, 16'h0003, 1'b0, 1'b1, 16'h8001, 16'h7FFF);
    check("inc_sat_s", {out_ovf[1], out_satd[1]}, 2'b11);
    directed(16'h7FFE, 16'h0003, 1'b0, 1'b0, 16'h8001, 16'h8001);
    check("inc_wrap_s", {out_neg[1], out_ovf[1], out_satd[1]}, 3'b110);
    directed(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 16'h8000);
    check("dec_sat_s", out_satd[1], 1'b1);
    directed(16'h1234, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h1234);
    check("step0_flags", {out_carry, out_ovf, out_satd}, 6'b000000);

    // Sticky: overflow with clear in the same cycle keeps it set, then a clean op clears it.
    drive(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    check("sticky_set_win", sticky_ovf, 2'b11);
    drive(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("sticky_clr", sticky_ovf, 2'b00);

    // Backpressure: four ops with out_ready low for three cycles mid-stream.
    for (int i = 0; i < 4; i++) sa[i] = W'($urandom);
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      in_valid = 1'b1; in_a = sa[k]; in_step = W'(k * 16'h3001); in_dec = k[0]; in_sat = k[1];
      @(negedge clk);
      acc = in_ready[0];
      if (cyc >= 3 && cyc < 5) check("stall_in_ready", in_ready, 2'b00);
      @(posedge clk); #1;
      if (acc) k++;
    end
    check("stream_done", k, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset while a result is held under backpressure discards it.
    drive(16'h0042, 16'h0001, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    check("rst_discard", out_valid, 2'b00);

    // Random traffic with random backpressure and clears.
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      in_a = ($urandom_range(0, 3) == 0) ? 16'h7FFF + W'($urandom_range(0, 2)) : W'($urandom);
      in_step = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
      in_dec = $urandom_range(0, 1) != 0;
      in_sat = $urandom_range(0, 1) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain", out_valid, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
